// File: rtl/sync_fifo_mwsr.sv
// Narrow-write / wide-read synchronous FIFO with show-ahead read data.
// Optional partial-word pad-and-commit enabled by SYNC_FIFO_MWSR_FLUSH_EN.
module sync_fifo_mwsr #(
  parameter int W_WIDTH = 16,
  parameter int R_WIDTH = 32,
  parameter int R_DEPTH = 16,
  parameter int W_DEPTH = R_DEPTH * R_WIDTH / W_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [W_WIDTH-1:0] wr_data,
  output logic               full,
`ifdef SYNC_FIFO_MWSR_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               rd_en,
  output logic [R_WIDTH-1:0] rd_data,
  output logic               empty
);

  localparam int RATIO = R_WIDTH / W_WIDTH;
  localparam int AW    = $clog2(W_DEPTH);
  localparam int RAW   = $clog2(R_DEPTH);
  localparam int LR    = $clog2(RATIO);

  typedef logic [AW:0] wptr_t;

  logic [W_WIDTH-1:0] mem_q [W_DEPTH];

  wptr_t        wptr_q, wptr_d;
  logic [RAW:0] rptr_q, rptr_d;
  wptr_t        rptr_n;
  wptr_t        occ;
  wptr_t        wptr_w;
  wptr_t        pad_off;
  wptr_t        pad_base;
  logic         pad;
  logic         wr_acc;
  logic         rd_acc;

  // Read pointer scaled into narrow units for occupancy and addressing.
  assign rptr_n = wptr_t'(rptr_q) << LR;
  assign occ    = wptr_q - rptr_n;
  assign full   = (occ == wptr_t'(W_DEPTH));
  assign empty  = (occ < wptr_t'(RATIO));
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign wptr_w = wptr_q + wptr_t'(wr_acc);

`ifdef SYNC_FIFO_MWSR_FLUSH_EN
  assign pad_off = wptr_w & wptr_t'(RATIO - 1);
  assign pad     = flush & (pad_off != '0);
`else
  assign pad_off = '0;
  assign pad     = 1'b0;
`endif

  assign pad_base = wptr_w - pad_off;
  assign wptr_d   = pad ? pad_base + wptr_t'(RATIO) : wptr_w;
  assign rptr_d   = rptr_q + (RAW+1)'(rd_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Pad lanes always lie after the lane written this cycle.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[AW-1:0]] <= wr_data;
    if (pad) begin
      for (int k = 0; k < RATIO; k++) begin
        if (wptr_t'(k) >= pad_off)
          mem_q[pad_base[AW-1:0] + AW'(k)] <= '0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RATIO; k++)
      rd_data[k*W_WIDTH +: W_WIDTH] = mem_q[rptr_n[AW-1:0] + AW'(k)];
  end

endmodule

// File: doc/sync_fifo_mwsr.md
SYNC_FIFO_MWSR -- requirements
Module: sync_fifo_mwsr

Interface
REQ-001 Parameter W_WIDTH, default 16, narrow write word width in bits.
REQ-002 Parameter R_WIDTH, default 32, wide read word width in bits; SHALL be W_WIDTH times a power of two.
REQ-003 Parameter R_DEPTH, default 16, capacity in wide words; SHALL be a power of two.
REQ-004 Parameter W_DEPTH, default R_DEPTH*R_WIDTH/W_WIDTH, capacity in narrow words; RATIO = R_WIDTH/W_WIDTH.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  narrow write request.
REQ-008 wr_data  input  W_WIDTH  narrow write data.
REQ-009 full  output  1  high when W_DEPTH narrow words are stored.
REQ-010 flush  input  1  pad-and-commit request for a partial wide word; present only with SYNC_FIFO_MWSR_FLUSH_EN.
REQ-011 rd_en  input  1  wide read request.
REQ-012 rd_data  output  R_WIDTH  head wide word, show-ahead.
REQ-013 empty  output  1  high when fewer than RATIO narrow words are stored.

Function
REQ-014 Storage SHALL be W_DEPTH narrow lanes; the write pointer advances in narrow units and the read pointer in wide units, each one bit wider than its address for wrap detection.
REQ-015 A write SHALL be accepted when wr_en=1 and full=0 at the edge; it stores wr_data at the write pointer and increments the pointer by 1.
REQ-016 A write with full=1 SHALL be dropped, with no state change.
REQ-017 Packing order: the first narrow word of a wide word SHALL occupy rd_data[W_WIDTH-1:0], the k-th narrow word bits [(k+1)*W_WIDTH-1 : k*W_WIDTH].
REQ-018 rd_data SHALL be combinational from the head wide entry (zero read latency) and is valid only while empty=0.
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0; the read pointer increments by 1 (RATIO narrow lanes freed).
REQ-020 A read with empty=1 SHALL be ignored, including while a partial wide word is pending.
REQ-021 Occupancy = write pointer - RATIO*read pointer, modulo 2*W_DEPTH; full = (occupancy == W_DEPTH); empty = (occupancy < RATIO).
REQ-022 Simultaneous accepted read and write SHALL both take effect in the same cycle; acceptance uses flags sampled before the edge.
REQ-023 Pointer wrap SHALL be seamless; data order SHALL be preserved across any number of wraps.
REQ-024 full and empty SHALL be combinational from the pointers and update in the cycle after the accepting edge.

Reset
REQ-025 rst_n=0 SHALL immediately clear both pointers, giving empty=1 and full=0, and discarding any partial word.
REQ-026 Reset asserted mid-operation SHALL abandon all stored data; memory contents need not be cleared.
REQ-027 Logic SHALL leave reset on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SYNC_FIFO_MWSR_FLUSH_EN SHALL control the flush feature.
REQ-029 With the macro defined: if flush=1 and the write pointer is not a multiple of RATIO, the write pointer SHALL advance to the next multiple of RATIO and the skipped lanes SHALL be written with zero.
REQ-030 With the macro defined: flush with an accepted write in the same cycle SHALL pad after that write; flush is a no-op if that write completes the wide word or no partial word exists.
REQ-031 With the macro defined: flush SHALL proceed when full=1, because the padded lanes are already within capacity.
REQ-032 Without the macro: the flush port and padding logic SHALL be absent, and partial words become readable only once completed by writes.

Verification
REQ-033 Reset, then write 16'h1111 and 16'h2222 -> empty=1 after the first write and 0 after the second; rd_data=32'h2222_1111.
REQ-034 Write 32 narrow words 0..31 with no reads -> full=1 after the 32nd; a 33rd write is dropped; 16 reads return {2k+1,2k} in order, and empty=1 after the last.
REQ-035 Fill to 30 words, then hold wr_en and rd_en together for 40 cycles -> occupancy oscillates without loss across the wrap; the output stream equals the input stream.
REQ-036 Write 3 words with no flush -> one wide word is readable; after it is read empty=1, and the third word is released only by a fourth write.
REQ-037 With the macro defined: write 16'hABCD, then flush -> next cycle empty=0 and rd_data=32'h0000_ABCD; flush with an empty FIFO changes nothing.
REQ-038 Assert rst_n=0 asynchronously mid-stream with 10 words stored -> empty=1 and full=0 immediately; the next writes start a fresh wide word.
